// File: rtl/hilo_mdu_sequencer.sv
// HI/LO multiply-divide-unit sequencer: 32-cycle radix-2 shift-add multiplier with mult/multu/madd/msub and mthi/mtlo.
// Latency 34 cycles Start->Done for multiplies; Stall asks the hazard unit to freeze the pipeline while the sequence runs.
module hilo_mdu_sequencer (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        RdHi,
    input  logic        RdLo,
    output logic        Busy,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut
);
    typedef enum logic [1:0] {IDLE, MUL, FIX} state_e;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MSUB  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic        neg_q, neg_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        signed_op;
    logic [31:0] a_mag, b_mag;
    logic [32:0] step_sum;
    logic [63:0] prod_fix;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        op_d      = op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        signed_op = (Op != OP_MULTU);
        // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
        a_mag     = A[31] ? (~A + 32'd1) : A;
        b_mag     = B[31] ? (~B + 32'd1) : B;
        step_sum  = {1'b0, prod_q[63:32]} + (mplier_q[0] ? {1'b0, mcand_q} : 33'd0);
        prod_fix  = neg_q ? (~prod_q + 64'd1) : prod_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (Op)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                            mcand_d  = signed_op ? a_mag : A;
                            mplier_d = signed_op ? b_mag : B;
                            neg_d    = signed_op & (A[31] ^ B[31]);
                            prod_d   = 64'd0;
                            cnt_d    = 5'd0;
                            op_d     = Op;
                            state_d  = MUL;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                prod_d   = {step_sum, prod_q[31:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                case (op_q)
                    OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_fix;
                    OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_fix;
                    default: {hi_d, lo_d} = prod_fix;
                endcase
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            prod_q   <= 64'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            neg_q    <= 1'b0;
            op_q     <= 3'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign Busy  = (state_q != IDLE);
    assign Stall = Busy & (Start | RdHi | RdLo);
    assign Done  = done_q;
    assign HiOut = hi_q;
    assign LoOut = lo_q;
endmodule
